// File: rtl/cacheaq_arb_pkg.sv
// Shared types for the cache access-queue arbiter: FSM encodings, source bit
// positions in the req/grant/pop vectors, and the default starvation limit.
package cacheaq_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_SECOND   = 2'd2,
    ST_MISSWAIT = 2'd3
  } state_t;

  localparam int SRC_RD  = 0;
  localparam int SRC_SW  = 1;
  localparam int SRC_WB  = 2;
  localparam int SRC_BUS = 3;

  localparam logic [2:0] STARVE_LIMIT_DEF = 3'd7;

endpackage

// File: rtl/cacheaq_arb_prio_pick.sv
// Combinational fixed-priority picker (bus > wb > sw > rd); any requester that
// is also flagged in promote beats every non-promoted requester.
module cacheaq_prio_pick
  import cacheaq_arb_pkg::*;
(
  input  logic [3:0] req,
  input  logic [3:0] promote,
  output logic [3:0] win
);

  logic [3:0] cand;

  always_comb begin
    cand = ((req & promote) != 4'b0000) ? (req & promote) : req;
    win  = 4'b0000;
    if (cand[SRC_BUS])     win[SRC_BUS] = 1'b1;
    else if (cand[SRC_WB]) win[SRC_WB]  = 1'b1;
    else if (cand[SRC_SW]) win[SRC_SW]  = 1'b1;
    else if (cand[SRC_RD]) win[SRC_RD]  = 1'b1;
  end

endmodule

// File: rtl/cacheaq_arb.sv
// Cache access-queue arbiter: picks one of {bus,wb,sw,rd}, issues one or two cache phases, pops on hit.
// Latency: req to pop strobe 2 cycles (one phase) / 3 cycles (two phases); holds while cache_ready is low.
// Optional starvation promotion for wb/sw/rd is built with CACHEAQ_ARB_STARVE_EN.
module cacheaq_arb
  import cacheaq_arb_pkg::*;
#(
  parameter logic [2:0] STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] req,
  input  logic [3:0] need_p1,
  input  logic       cache_ready,
  input  logic       cache_miss,
  input  logic       fill_done,
  output logic [3:0] grant,
  output logic [3:0] pop,
  output logic       issue_valid,
  output logic       issue_phase,
  output logic       busy
);

  state_t     state, state_nxt;
  logic [3:0] grant_nxt;
  logic [3:0] promote;
  logic [3:0] win;
  logic       granted_req;
  logic       granted_p1;

  cacheaq_prio_pick u_pick (
    .req     (req),
    .promote (promote),
    .win     (win)
  );

  assign granted_req = |(req & grant);
  assign granted_p1  = |(need_p1 & grant);
  assign busy        = (state != ST_IDLE);

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    pop         = 4'b0000;
    issue_valid = 1'b0;
    issue_phase = 1'b0;
    case (state)
      ST_IDLE: begin
        grant_nxt = 4'b0000;
        if (req != 4'b0000) begin
          grant_nxt = win;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE, ST_SECOND: begin
        issue_valid = 1'b1;
        issue_phase = (state == ST_SECOND);
        // A drained queue wins over any cache response for the same cycle.
        if (!granted_req) begin
          state_nxt = ST_IDLE;
          grant_nxt = 4'b0000;
        end else if (cache_ready) begin
          if (cache_miss) begin
            state_nxt = ST_MISSWAIT;
          end else if (state == ST_ISSUE && granted_p1) begin
            state_nxt = ST_SECOND;
          end else begin
            pop       = clr ? 4'b0000 : grant;
            state_nxt = ST_IDLE;
            grant_nxt = 4'b0000;
          end
        end
      end
      ST_MISSWAIT: begin
        if (!granted_req) begin
          state_nxt = ST_IDLE;
          grant_nxt = 4'b0000;
        end else if (fill_done) begin
          state_nxt = ST_ISSUE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= ST_IDLE;
      grant <= 4'b0000;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
    end
  end

`ifdef CACHEAQ_ARB_STARVE_EN
  // Wait counters for rd/sw/wb, indexed by their source bit; bus never starves.
  logic [2:0] wait_cnt [3];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 3; i++) wait_cnt[i] <= 3'd0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!req[i] || (state == ST_IDLE && win[i]))
          wait_cnt[i] <= 3'd0;
        else if ((pop != 4'b0000) && !pop[i] && (wait_cnt[i] != STARVE_LIMIT))
          wait_cnt[i] <= wait_cnt[i] + 3'd1;
      end
    end
  end

  always_comb begin
    promote = 4'b0000;
    for (int i = 0; i < 3; i++) promote[i] = (wait_cnt[i] == STARVE_LIMIT);
  end
`else
  assign promote = 4'b0000;
`endif

endmodule

// File: tb/tb_cacheaq_arb.sv
// Directed table-driven bench for cacheaq_arb plus a starvation sequence
// whose expectation follows whether CACHEAQ_ARB_STARVE_EN is defined.
module tb_cacheaq_arb;

  logic       clk = 1'b0;
  logic       clr;
  logic [3:0] req, need_p1;
  logic       cache_ready, cache_miss, fill_done;
  logic [3:0] grant, pop;
  logic       issue_valid, issue_phase, busy;

  always #5 clk = ~clk;

  cacheaq_arb #(.STARVE_LIMIT(3'd2)) dut (
    .clk         (clk),
    .clr         (clr),
    .req         (req),
    .need_p1     (need_p1),
    .cache_ready (cache_ready),
    .cache_miss  (cache_miss),
    .fill_done   (fill_done),
    .grant       (grant),
    .pop         (pop),
    .issue_valid (issue_valid),
    .issue_phase (issue_phase),
    .busy        (busy)
  );

  typedef struct {
    logic       clr;
    logic [3:0] req;
    logic [3:0] np;
    logic       cr;
    logic       miss;
    logic       fill;
    logic [3:0] g;
    logic [3:0] p;
    logic       iv;
    logic       ip;
    logic       b;
  } vec_t;

  vec_t vq[$];
  int   tests = 0;
  int   fails = 0;

  task automatic add(input logic c, input logic [3:0] r, input logic [3:0] n,
                     input logic cr, input logic m, input logic f,
                     input logic [3:0] g, input logic [3:0] p,
                     input logic iv, input logic ip, input logic b);
    vec_t v;
    v = '{clr: c, req: r, np: n, cr: cr, miss: m, fill: f,
          g: g, p: p, iv: iv, ip: ip, b: b};
    vq.push_back(v);
  endtask

  task automatic drive(input logic c, input logic [3:0] r, input logic [3:0] n,
                       input logic cr, input logic m, input logic f);
    clr = c; req = r; need_p1 = n; cache_ready = cr; cache_miss = m; fill_done = f;
  endtask

  logic [10:0] got, exp_o;
  logic [3:0]  exp_pop [12];

  initial begin
    drive(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Each row is one cycle: inputs applied after the falling edge, outputs checked 1 ns later.
    //  clr req      need_p1  rdy  miss fill | grant    pop      iv   ip   busy
    // Reset state, and clr overriding a full request set.
    add(1, 4'b1111, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add(0, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    // sw beats rd; one-phase pops; rd follows once sw drains.
    add(0, 4'b0011, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add(0, 4'b0011, 4'b0000, 1, 0, 0, 4'b0010, 4'b0010, 1, 0, 1);
    add(0, 4'b0001, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add(0, 4'b0001, 4'b0000, 1, 0, 0, 4'b0001, 4'b0001, 1, 0, 1);
    add(0, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    // Two-phase rd entry: phase 0 then phase 1, single pop after phase 1.
    add(0, 4'b0001, 4'b0001, 1, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add(0, 4'b0001, 4'b0001, 1, 0, 0, 4'b0001, 4'b0000, 1, 0, 1);
    add(0, 4'b0001, 4'b0001, 1, 0, 0, 4'b0001, 4'b0001, 1, 1, 1);
    add(0, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    // cache_ready low holds ISSUE; an unqualified miss is ignored.
    add(0, 4'b0100, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add(0, 4'b0100, 4'b0000, 0, 0, 0, 4'b0100, 4'b0000, 1, 0, 1);
    add(0, 4'b0100, 4'b0000, 0, 1, 0, 4'b0100, 4'b0000, 1, 0, 1);
    add(0, 4'b0100, 4'b0000, 1, 0, 0, 4'b0100, 4'b0100, 1, 0, 1);
    add(0, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    // All request: bus wins; bus queue clears mid-ISSUE -> abort, then wb wins and aborts too.
    add(0, 4'b1111, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add(0, 4'b1111, 4'b0000, 0, 0, 0, 4'b1000, 4'b0000, 1, 0, 1);
    add(0, 4'b0111, 4'b0000, 1, 0, 0, 4'b1000, 4'b0000, 1, 0, 1);
    add(0, 4'b0111, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add(0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0100, 4'b0000, 1, 0, 1);
    add(0, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    // Miss in SECOND, fill_done 5 cycles later, replay from phase 0, one pop.
    add(0, 4'b0010, 4'b0010, 1, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add(0, 4'b0010, 4'b0010, 1, 0, 0, 4'b0010, 4'b0000, 1, 0, 1);
    add(0, 4'b0010, 4'b0010, 1, 1, 0, 4'b0010, 4'b0000, 1, 1, 1);
    for (int k = 0; k < 4; k++)
      add(0, 4'b0010, 4'b0010, 1, 0, 0, 4'b0010, 4'b0000, 0, 0, 1);
    add(0, 4'b0010, 4'b0010, 1, 0, 1, 4'b0010, 4'b0000, 0, 0, 1);
    add(0, 4'b0010, 4'b0010, 1, 0, 0, 4'b0010, 4'b0000, 1, 0, 1);
    add(0, 4'b0010, 4'b0010, 1, 0, 0, 4'b0010, 4'b0010, 1, 1, 1);
    add(0, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    // Bus misses, then its queue clears in MISSWAIT (with a coincident fill_done).
    add(0, 4'b1000, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add(0, 4'b1000, 4'b0000, 1, 1, 0, 4'b1000, 4'b0000, 1, 0, 1);
    add(0, 4'b1000, 4'b0000, 1, 0, 0, 4'b1000, 4'b0000, 0, 0, 1);
    add(0, 4'b0000, 4'b0000, 1, 0, 1, 4'b1000, 4'b0000, 0, 0, 1);
    add(0, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    // clr in SECOND suppresses the pop and returns everything to idle.
    add(0, 4'b0001, 4'b0001, 1, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add(0, 4'b0001, 4'b0001, 1, 0, 0, 4'b0001, 4'b0000, 1, 0, 1);
    add(1, 4'b0001, 4'b0001, 1, 0, 0, 4'b0001, 4'b0000, 1, 1, 1);
    add(0, 4'b0001, 4'b0001, 1, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add(0, 4'b0000, 4'b0000, 1, 0, 0, 4'b0001, 4'b0000, 1, 0, 1);
    add(0, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);

    @(negedge clk);
    @(negedge clk);

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].clr, vq[i].req, vq[i].np, vq[i].cr, vq[i].miss, vq[i].fill);
      #1;
      got   = {grant, pop, issue_valid, issue_phase, busy};
      exp_o = {vq[i].g, vq[i].p, vq[i].iv, vq[i].ip, vq[i].b};
      tests++;
      if (got !== exp_o) begin
        fails++;
        $display("FAIL vec%0d: got grant=%b pop=%b iv=%b ip=%b busy=%b, want grant=%b pop=%b iv=%b ip=%b busy=%b",
                 i, grant, pop, issue_valid, issue_phase, busy,
                 vq[i].g, vq[i].p, vq[i].iv, vq[i].ip, vq[i].b);
      end
    end

    // bus and rd both always requesting, one-phase hits; pop observed every cycle.
    for (int k = 0; k < 12; k++) exp_pop[k] = (k % 2 == 1) ? 4'b1000 : 4'b0000;
`ifdef CACHEAQ_ARB_STARVE_EN
    exp_pop[5]  = 4'b0001;
    exp_pop[11] = 4'b0001;
`endif
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      drive(1'b0, 4'b1001, 4'b0000, 1'b1, 1'b0, 1'b0);
      #1;
      tests++;
      if (pop !== exp_pop[k]) begin
        fails++;
        $display("FAIL starve_pop%0d: got pop=%b, want pop=%b", k, pop, exp_pop[k]);
      end
    end

    @(negedge clk);
    drive(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
